// File: rtl/kbd_fifo.sv
// Keyboard receive buffer: scancode FIFO feeding an 8042-style output latch
// (port 60h data, port 64h status) with a level IRQ1. Optional KBD_BREAK_FOLD_EN folds F0 break prefixes.
module kbd_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_hit,
  input  logic          rd,
  input  logic          clear,
  input  logic          irq_en,
  output logic [7:0]    data_o,
  output logic [7:0]    status_o,
  output logic [AW:0]   count_o,
  output logic          irq
);

  // Handshake: a byte enters on each rising edge of ps2_hit (no back-pressure;
  // a full FIFO drops it and flags overflow). The latch is "valid" while obf=1
  // and the CPU acknowledges with a one-cycle rd; a new byte is latched on a
  // later edge where obf=0 and the FIFO holds something.
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_data;
  logic          r_obf, r_ovf, r_hit_d, r_irq;

  logic          w_hit_edge, w_accept, w_full, w_nonempty;
  logic          w_push, w_drop, w_load, w_obf_nxt;
  logic [7:0]    w_byte;

`ifdef KBD_BREAK_FOLD_EN
  logic          r_fold, w_fold_nxt, w_is_break, w_is_prefix;
`endif

  always_comb begin
    w_hit_edge = ps2_hit & ~r_hit_d;
    w_full     = (r_count == (AW+1)'(DEPTH));
    w_nonempty = (r_count != '0);
`ifdef KBD_BREAK_FOLD_EN
    // A pending F0 turns the next real scancode into its break code; E0/E1 ride through.
    w_is_break  = (ps2_data == 8'hF0) & ~r_fold;
    w_is_prefix = (ps2_data == 8'hE0) | (ps2_data == 8'hE1);
    w_byte      = (r_fold & ~w_is_prefix) ? (ps2_data | 8'h80) : ps2_data;
    w_accept    = w_hit_edge & ~w_is_break;
    w_fold_nxt  = r_fold;
    if (w_hit_edge) begin
      if (w_is_break)        w_fold_nxt = 1'b1;
      else if (!w_is_prefix) w_fold_nxt = 1'b0;
    end
`else
    w_byte   = ps2_data;
    w_accept = w_hit_edge;
`endif
    w_push    = w_accept & ~w_full;
    w_drop    = w_accept & w_full;
    w_load    = ~r_obf & w_nonempty;
    w_obf_nxt = w_load | (r_obf & ~rd);
  end

  always_ff @(posedge clock) begin
    if (!clear && w_push) r_mem[r_wptr] <= w_byte;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= 8'h00;
      r_obf   <= 1'b0;
      r_ovf   <= 1'b0;
      r_hit_d <= 1'b0;
      r_irq   <= 1'b0;
`ifdef KBD_BREAK_FOLD_EN
      r_fold  <= 1'b0;
`endif
    end else begin
      r_hit_d <= ps2_hit;
      if (clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_obf   <= 1'b0;
        r_ovf   <= 1'b0;
        r_irq   <= 1'b0;
`ifdef KBD_BREAK_FOLD_EN
        r_fold  <= 1'b0;
`endif
      end else begin
        r_wptr  <= r_wptr + AW'(w_push);
        r_rptr  <= r_rptr + AW'(w_load);
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_load);
        if (w_load) r_data <= r_mem[r_rptr];
        if (w_drop) r_ovf  <= 1'b1;
        r_obf   <= w_obf_nxt;
        r_irq   <= w_obf_nxt & irq_en;
`ifdef KBD_BREAK_FOLD_EN
        r_fold  <= w_fold_nxt;
`endif
      end
    end
  end

  assign data_o   = r_data;
  assign count_o  = r_count;
  assign irq      = r_irq;
  assign status_o = {4'b0000, w_full, r_ovf, w_nonempty, r_obf};

endmodule
